// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and constants for the register-file scoreboard
//            slice: dump FSM state encoding, default geometry and the
//            hard-wired zero-register index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int c_default_data_w = 32;
   localparam int c_default_addr_w = 5;

   // Register 0 reads as zero, is never busy, and ignores writes/issues.
   localparam int c_zero_reg = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_if
// Purpose  : Bundles the decode/writeback/debug signals of the register
//            file so the pipeline (master) and register file (slave) share
//            one port.
// Ports    : master drives write, read-address, issue and dump_start;
//            slave drives read data, read_busy, dump stream and taps.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int DATA_W   = c_default_data_w,
   parameter int ADDR_W   = c_default_addr_w,
   parameter int NUM_READ = 2,
   parameter int NUM_TAPS = 4
);

   logic                         ctrl_writeEnable;
   logic [ADDR_W-1:0]            ctrl_writeReg;
   logic [DATA_W-1:0]            data_writeReg;
   logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg;
   logic [NUM_READ*DATA_W-1:0]   data_readReg;
   logic [NUM_READ-1:0]          read_busy;
   logic                         ctrl_issueEnable;
   logic [ADDR_W-1:0]            ctrl_issueReg;
   logic                         dump_start;
   logic                         dump_valid;
   logic [ADDR_W-1:0]            dump_addr;
   logic [DATA_W-1:0]            dump_data;
   logic                         dump_done;
   logic [NUM_TAPS*DATA_W-1:0]   taps;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
             ctrl_issueEnable, ctrl_issueReg, dump_start,
      input  data_readReg, read_busy, dump_valid, dump_addr, dump_data,
             dump_done, taps
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
             ctrl_issueEnable, ctrl_issueReg, dump_start,
      output data_readReg, read_busy, dump_valid, dump_addr, dump_data,
             dump_done, taps
   );

endinterface
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Purpose  : One combinational read port: selects a register from the
//            flattened storage, looks up its busy bit and resolves a
//            same-cycle writeback to the same address.
//            Build option REGFILE_WRITE_BYPASS_EN: when defined the
//            writeback data is forwarded and the port is not busy; when
//            undefined the stored value is returned and the port reports
//            busy so the consumer stalls one cycle.
// Ports    : i_mem_flat  all registers, register j at [j*DATA_W +: DATA_W]
//            i_busy      per-register pending bits
//            i_rd_addr   read address
//            i_wr_en/i_wr_addr(/i_wr_data) same-cycle writeback
//            o_rd_data   read data
//            o_rd_busy   source has an unwritten result
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = c_default_data_w,
   parameter int ADDR_W = c_default_addr_w
) (
   input  wire [(2**ADDR_W)*DATA_W-1:0] i_mem_flat,
   input  wire [(2**ADDR_W)-1:0]        i_busy,
   input  wire [ADDR_W-1:0]             i_rd_addr,
   input  wire                          i_wr_en,
   input  wire [ADDR_W-1:0]             i_wr_addr,
`ifdef REGFILE_WRITE_BYPASS_EN
   input  wire [DATA_W-1:0]             i_wr_data,
`endif
   output logic [DATA_W-1:0]            o_rd_data,
   output logic                         o_rd_busy
);

   localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(c_zero_reg);

   logic [DATA_W-1:0] w_stored;
   logic              w_hit;

   assign w_stored = i_mem_flat[i_rd_addr*DATA_W +: DATA_W];

   // A writeback to r0 is discarded, so it never collides with a read.
   assign w_hit = i_wr_en && (i_wr_addr != c_zero_addr) && (i_wr_addr == i_rd_addr);

`ifdef REGFILE_WRITE_BYPASS_EN
   assign o_rd_data = w_hit ? i_wr_data : w_stored;
   assign o_rd_busy = i_busy[i_rd_addr] & ~w_hit;
`else
   assign o_rd_data = w_stored;
   assign o_rd_busy = i_busy[i_rd_addr] | w_hit;
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Parametrised register file with NUM_READ combinational read
//            ports, per-register busy scoreboard, a sequential debug dump
//            engine (one register per cycle) and live taps of r1..NUM_TAPS.
//            Build option REGFILE_WRITE_BYPASS_EN selects write-to-read
//            forwarding on the read ports (see regfile_read_port).
// Ports    : clock       rising-edge system clock
//            ctrl_reset  synchronous active-high reset
//            bus         regfile_scoreboard_if.slave (write, read, issue,
//                        dump stream, taps)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W   = c_default_data_w,
   parameter int ADDR_W   = c_default_addr_w,
   parameter int NUM_READ = 2,
   parameter int NUM_TAPS = 4
) (
   input  wire                  clock,
   input  wire                  ctrl_reset,
   regfile_scoreboard_if.slave  bus
);

   localparam int                DEPTH       = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(c_zero_reg);
   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH-1);

   logic [DATA_W-1:0]       r_mem [DEPTH];
   logic [DEPTH-1:0]        r_busy;
   logic [DEPTH-1:0]        w_busy_next;
   logic [DEPTH*DATA_W-1:0] w_mem_flat;
   logic                    w_wr_valid;
   logic                    w_iss_valid;

   dump_state_t             r_state;
   logic                    r_dump_valid;
   logic                    r_dump_done;
   logic [ADDR_W-1:0]       r_dump_addr;
   logic [DATA_W-1:0]       r_dump_data;
   logic [ADDR_W-1:0]       w_next_idx;
   logic [DATA_W-1:0]       w_next_data;

   assign w_wr_valid  = bus.ctrl_writeEnable && (bus.ctrl_writeReg != c_zero_addr);
   assign w_iss_valid = bus.ctrl_issueEnable && (bus.ctrl_issueReg != c_zero_addr);

   // ------------------------------------------------------------------
   // Storage and scoreboard
   // ------------------------------------------------------------------
   always_comb begin
      w_busy_next = r_busy;
      if (w_wr_valid) begin
         w_busy_next[bus.ctrl_writeReg] = 1'b0;
      end
      // Applied after the clear so a new producer issued in the same
      // cycle as the old one retires keeps the register pending.
      if (w_iss_valid) begin
         w_busy_next[bus.ctrl_issueReg] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int j = 0; j < DEPTH; j++) begin
            r_mem[j] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_valid) begin
            r_mem[bus.ctrl_writeReg] <= bus.data_writeReg;
         end
         r_busy <= w_busy_next;
      end
   end

   // ------------------------------------------------------------------
   // Read ports and taps
   // ------------------------------------------------------------------
   for (genvar j = 0; j < DEPTH; j++) begin : g_flat
      assign w_mem_flat[j*DATA_W +: DATA_W] = r_mem[j];
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_read
      regfile_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_port (
         .i_mem_flat (w_mem_flat),
         .i_busy     (r_busy),
         .i_rd_addr  (bus.ctrl_readReg[i*ADDR_W +: ADDR_W]),
         .i_wr_en    (bus.ctrl_writeEnable),
         .i_wr_addr  (bus.ctrl_writeReg),
`ifdef REGFILE_WRITE_BYPASS_EN
         .i_wr_data  (bus.data_writeReg),
`endif
         .o_rd_data  (bus.data_readReg[i*DATA_W +: DATA_W]),
         .o_rd_busy  (bus.read_busy[i])
      );
   end

   for (genvar k = 1; k <= NUM_TAPS; k++) begin : g_taps
      assign bus.taps[(k-1)*DATA_W +: DATA_W] = r_mem[k];
   end

   // ------------------------------------------------------------------
   // Dump engine
   // ------------------------------------------------------------------
   // The dump outputs are registered, so the beat for index n is loaded
   // at the edge that enters that beat. Folding in the write committed
   // at that same edge makes dump_data equal the register contents for
   // the whole beat, while a write during the beat lands only afterwards.
   assign w_next_idx  = r_dump_addr + 1'b1;
   assign w_next_data = (w_wr_valid && (bus.ctrl_writeReg == w_next_idx))
                        ? bus.data_writeReg : r_mem[w_next_idx];

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         r_state      <= ST_IDLE;
         r_dump_valid <= 1'b0;
         r_dump_done  <= 1'b0;
         r_dump_addr  <= '0;
         r_dump_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_dump_done <= 1'b0;
               if (bus.dump_start) begin
                  r_state      <= ST_SCAN;
                  r_dump_valid <= 1'b1;
                  r_dump_addr  <= c_zero_addr;
                  // First beat is r0, which is hard-wired to zero.
                  r_dump_data  <= '0;
               end
            end
            ST_SCAN: begin
               if (r_dump_addr == c_last_addr) begin
                  r_state      <= ST_DONE;
                  r_dump_valid <= 1'b0;
                  r_dump_done  <= 1'b1;
                  r_dump_addr  <= '0;
                  r_dump_data  <= '0;
               end else begin
                  r_dump_addr  <= w_next_idx;
                  r_dump_data  <= w_next_data;
               end
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               r_dump_done <= 1'b0;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_dump_valid <= 1'b0;
               r_dump_done  <= 1'b0;
               r_dump_addr  <= '0;
               r_dump_data  <= '0;
            end
         endcase
      end
   end

   assign bus.dump_valid = r_dump_valid;
   assign bus.dump_done  = r_dump_done;
   assign bus.dump_addr  = r_dump_addr;
   assign bus.dump_data  = r_dump_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Self-checking bench for regfile_scoreboard. A default-geometry
//            instance is compared against an array-based reference model;
//            a second 16-bit, 3-port, 2-tap instance is checked with
//            constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
   import regfile_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int NT    = 4;
   localparam int DEPTH = 32;
   localparam int SDW   = 16;
   localparam int SNR   = 3;
   localparam int SNT   = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Reference model: register contents and pending bits
   logic [DW-1:0] m_mem  [DEPTH];
   logic          m_busy [DEPTH];

   regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .NUM_TAPS(NT)) bus ();
   regfile_scoreboard_if #(.DATA_W(SDW), .ADDR_W(AW), .NUM_READ(SNR), .NUM_TAPS(SNT)) sbus ();

   regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .NUM_TAPS(NT)) dut (
      .clock      (clk),
      .ctrl_reset (rst),
      .bus        (bus)
   );

   regfile_scoreboard #(.DATA_W(SDW), .ADDR_W(AW), .NUM_READ(SNR), .NUM_TAPS(SNT)) dut_s (
      .clock      (clk),
      .ctrl_reset (rst),
      .bus        (sbus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Advance one rising edge and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int j = 0; j < DEPTH; j++) begin
            m_mem[j]  = '0;
            m_busy[j] = 1'b0;
         end
      end else begin
         if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0) begin
            m_mem[bus.ctrl_writeReg]  = bus.data_writeReg;
            m_busy[bus.ctrl_writeReg] = 1'b0;
         end
         if (bus.ctrl_issueEnable && bus.ctrl_issueReg != 0) begin
            m_busy[bus.ctrl_issueReg] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle();
      bus.ctrl_writeEnable = 1'b0;
      bus.ctrl_writeReg    = '0;
      bus.data_writeReg    = '0;
      bus.ctrl_readReg     = '0;
      bus.ctrl_issueEnable = 1'b0;
      bus.ctrl_issueReg    = '0;
      bus.dump_start       = 1'b0;
   endtask

   task automatic idle_small();
      sbus.ctrl_writeEnable = 1'b0;
      sbus.ctrl_writeReg    = '0;
      sbus.data_writeReg    = '0;
      sbus.ctrl_readReg     = '0;
      sbus.ctrl_issueEnable = 1'b0;
      sbus.ctrl_issueReg    = '0;
      sbus.dump_start       = 1'b0;
   endtask

   function automatic logic same_cycle_write(input int a);
      return bus.ctrl_writeEnable && (int'(bus.ctrl_writeReg) == a) && (a != 0);
   endfunction

   function automatic logic [DW-1:0] exp_data(input int a);
`ifdef REGFILE_WRITE_BYPASS_EN
      if (same_cycle_write(a)) return bus.data_writeReg;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input int a);
`ifdef REGFILE_WRITE_BYPASS_EN
      return m_busy[a] && !same_cycle_write(a);
`else
      return m_busy[a] || same_cycle_write(a);
`endif
   endfunction

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.dump_valid !== 1'b0 || bus.dump_done !== 1'b0 ||
          bus.dump_addr !== '0 || bus.dump_data !== '0) begin
         errors++;
         $display("FAIL reset_dump: valid=%b done=%b addr=%0d data=%h, expected all zero",
                  bus.dump_valid, bus.dump_done, bus.dump_addr, bus.dump_data);
      end
      for (int a = 0; a < DEPTH; a++) begin
         bus.ctrl_readReg[0 +: AW] = AW'(a);
         bus.ctrl_readReg[AW +: AW] = AW'(DEPTH - 1 - a);
         #1;
         checks++;
         if (bus.data_readReg !== '0 || bus.read_busy !== '0) begin
            errors++;
            $display("FAIL reset_read r%0d: data=%h busy=%b, expected 0/00", a,
                     bus.data_readReg, bus.read_busy);
         end
      end
      checks++;
      if (bus.taps !== '0) begin
         errors++;
         $display("FAIL reset_taps: got %h expected 0", bus.taps);
      end
   endtask

   task automatic test_write();
      idle();
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd5;
      bus.data_writeReg    = 32'hDEADBEEF;
      tick();
      bus.ctrl_writeReg    = 5'd0;
      bus.data_writeReg    = 32'h00001234;
      tick();
      idle();
      bus.ctrl_readReg[0 +: AW] = 5'd5;
      bus.ctrl_readReg[AW +: AW] = 5'd0;
      #1;
      checks++;
      if (bus.data_readReg[0 +: DW] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_r5: got %h expected deadbeef", bus.data_readReg[0 +: DW]);
      end
      checks++;
      if (bus.data_readReg[DW +: DW] !== 32'h0 || bus.read_busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL write_r0: data=%h busy=%b expected 0/0",
                  bus.data_readReg[DW +: DW], bus.read_busy[1]);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      bus.ctrl_issueEnable = 1'b1;
      bus.ctrl_issueReg    = 5'd7;
      tick();
      idle();
      bus.ctrl_readReg[0 +: AW] = 5'd7;
      #1;
      checks++;
      if (bus.read_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_issue: busy=%b expected 1", bus.read_busy[0]);
      end
      // writeback and new issue of r7 together: the new producer wins
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd7;
      bus.data_writeReg    = 32'h55;
      bus.ctrl_issueEnable = 1'b1;
      bus.ctrl_issueReg    = 5'd7;
      tick();
      idle();
      bus.ctrl_readReg[0 +: AW] = 5'd7;
      #1;
      checks++;
      if (bus.read_busy[0] !== 1'b1 || bus.data_readReg[0 +: DW] !== 32'h55) begin
         errors++;
         $display("FAIL sb_wb_and_issue: busy=%b data=%h expected 1/00000055",
                  bus.read_busy[0], bus.data_readReg[0 +: DW]);
      end
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd7;
      bus.data_writeReg    = 32'h66;
      tick();
      idle();
      bus.ctrl_readReg[0 +: AW] = 5'd7;
      #1;
      checks++;
      if (bus.read_busy[0] !== 1'b0 || bus.data_readReg[0 +: DW] !== 32'h66) begin
         errors++;
         $display("FAIL sb_wb_only: busy=%b data=%h expected 0/00000066",
                  bus.read_busy[0], bus.data_readReg[0 +: DW]);
      end
      bus.ctrl_issueEnable = 1'b1;
      bus.ctrl_issueReg    = 5'd0;
      tick();
      idle();
      #1;
      checks++;
      if (bus.read_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_issue_r0: busy=%b expected 0", bus.read_busy[0]);
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] want_d;
      logic          want_b;
      idle();
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd3;
      bus.data_writeReg    = 32'h11111111;
      tick();
      bus.data_writeReg    = 32'hA5A5A5A5;
      bus.ctrl_readReg[0 +: AW]  = 5'd3;
      bus.ctrl_readReg[AW +: AW] = 5'd3;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      want_d = 32'hA5A5A5A5;
      want_b = 1'b0;
`else
      want_d = 32'h11111111;
      want_b = 1'b1;
`endif
      for (int p = 0; p < NR; p++) begin
         checks++;
         if (bus.data_readReg[p*DW +: DW] !== want_d || bus.read_busy[p] !== want_b) begin
            errors++;
            $display("FAIL bypass_port%0d: data=%h busy=%b expected %h/%b", p,
                     bus.data_readReg[p*DW +: DW], bus.read_busy[p], want_d, want_b);
         end
      end
      tick();
      idle();
      bus.ctrl_readReg[0 +: AW] = 5'd3;
      #1;
      checks++;
      if (bus.data_readReg[0 +: DW] !== 32'hA5A5A5A5 || bus.read_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL bypass_after: data=%h busy=%b expected a5a5a5a5/0",
                  bus.data_readReg[0 +: DW], bus.read_busy[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         bus.ctrl_writeEnable = 1'($urandom_range(0, 1));
         bus.ctrl_writeReg    = AW'($urandom_range(0, 7));
         bus.data_writeReg    = $urandom;
         bus.ctrl_issueEnable = 1'($urandom_range(0, 1));
         bus.ctrl_issueReg    = AW'($urandom_range(0, 7));
         for (int p = 0; p < NR; p++) begin
            if ($urandom_range(0, 3) == 0) bus.ctrl_readReg[p*AW +: AW] = bus.ctrl_writeReg;
            else bus.ctrl_readReg[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
         end
         #1;
         for (int p = 0; p < NR; p++) begin
            int a;
            a = int'(bus.ctrl_readReg[p*AW +: AW]);
            checks++;
            if (bus.data_readReg[p*DW +: DW] !== exp_data(a) || bus.read_busy[p] !== exp_busy(a)) begin
               errors++;
               $display("FAIL random_read n=%0d port%0d r%0d: data=%h busy=%b expected %h/%b",
                        n, p, a, bus.data_readReg[p*DW +: DW], bus.read_busy[p],
                        exp_data(a), exp_busy(a));
            end
         end
         tick();
         checks++;
         if (bus.taps !== {m_mem[4], m_mem[3], m_mem[2], m_mem[1]}) begin
            errors++;
            $display("FAIL random_taps n=%0d: got %h expected %h", n, bus.taps,
                     {m_mem[4], m_mem[3], m_mem[2], m_mem[1]});
         end
      end
      idle();
   endtask

   task automatic test_dump();
      idle();
      for (int r = 1; r < DEPTH; r++) begin
         bus.ctrl_writeEnable = 1'b1;
         bus.ctrl_writeReg    = AW'(r);
         bus.data_writeReg    = DW'(r);
         tick();
      end
      idle();
      bus.dump_start = 1'b1;
      tick();
      for (int k = 0; k < DEPTH; k++) begin
         // writes during the scan, often aimed at the current or next index
         bus.dump_start       = (k == 15);
         bus.ctrl_writeEnable = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0:       bus.ctrl_writeReg = AW'(k);
            1:       bus.ctrl_writeReg = AW'(k + 1);
            default: bus.ctrl_writeReg = AW'($urandom_range(0, DEPTH - 1));
         endcase
         bus.data_writeReg = $urandom;
         #1;
         checks++;
         if (bus.dump_valid !== 1'b1 || bus.dump_done !== 1'b0 ||
             int'(bus.dump_addr) !== k || bus.dump_data !== m_mem[k]) begin
            errors++;
            $display("FAIL dump_beat %0d: valid=%b done=%b addr=%0d data=%h expected 1/0/%0d/%h",
                     k, bus.dump_valid, bus.dump_done, bus.dump_addr, bus.dump_data, k, m_mem[k]);
         end
         tick();
      end
      idle();
      bus.dump_start = 1'b1;
      checks++;
      if (bus.dump_done !== 1'b1 || bus.dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL dump_done_pulse: done=%b valid=%b expected 1/0", bus.dump_done, bus.dump_valid);
      end
      tick();
      bus.dump_start = 1'b0;
      checks++;
      if (bus.dump_done !== 1'b0 || bus.dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL dump_after_done: done=%b valid=%b expected 0/0", bus.dump_done, bus.dump_valid);
      end
      tick();
      checks++;
      if (bus.dump_valid !== 1'b0 || bus.dump_done !== 1'b0) begin
         errors++;
         $display("FAIL dump_start_in_done: valid=%b done=%b expected 0/0",
                  bus.dump_valid, bus.dump_done);
      end
   endtask

   task automatic test_dump_reset();
      int seen_done;
      idle();
      bus.dump_start = 1'b1;
      tick();
      bus.dump_start = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 5'd10) begin
         errors++;
         $display("FAIL dump_beat10: valid=%b addr=%0d expected 1/10", bus.dump_valid, bus.dump_addr);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.dump_valid !== 1'b0 || bus.dump_done !== 1'b0 ||
          bus.dump_addr !== '0 || bus.dump_data !== '0) begin
         errors++;
         $display("FAIL dump_abort: valid=%b done=%b addr=%0d data=%h expected all zero",
                  bus.dump_valid, bus.dump_done, bus.dump_addr, bus.dump_data);
      end
      seen_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.dump_done !== 1'b0 || bus.dump_valid !== 1'b0) seen_done++;
         tick();
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL dump_abort_quiet: %0d active cycles after abort, expected 0", seen_done);
      end
      for (int a = 0; a < DEPTH; a++) begin
         bus.ctrl_readReg[0 +: AW] = AW'(a);
         #1;
         checks++;
         if (bus.data_readReg[0 +: DW] !== m_mem[a] || bus.data_readReg[0 +: DW] !== '0) begin
            errors++;
            $display("FAIL abort_clear r%0d: got %h expected 0", a, bus.data_readReg[0 +: DW]);
         end
      end
   endtask

   task automatic test_small();
      logic [SDW-1:0] want;
      idle_small();
      sbus.ctrl_writeEnable = 1'b1;
      sbus.ctrl_writeReg    = 5'd1;
      sbus.data_writeReg    = 16'h00FF;
      tick();
      sbus.ctrl_writeReg    = 5'd2;
      sbus.data_writeReg    = 16'h0F0F;
      tick();
      idle_small();
      sbus.ctrl_readReg = {5'd0, 5'd2, 5'd1};
      #1;
      checks++;
      if (sbus.taps !== 32'h0F0F00FF) begin
         errors++;
         $display("FAIL small_taps: got %h expected 0f0f00ff", sbus.taps);
      end
      checks++;
      if (sbus.data_readReg !== 48'h0000_0F0F_00FF || sbus.read_busy !== 3'b000) begin
         errors++;
         $display("FAIL small_reads: data=%h busy=%b expected 00000f0f00ff/000",
                  sbus.data_readReg, sbus.read_busy);
      end
      sbus.ctrl_writeEnable = 1'b1;
      sbus.ctrl_writeReg    = 5'd2;
      sbus.data_writeReg    = 16'h1234;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      want = 16'h1234;
`else
      want = 16'h0F0F;
`endif
      checks++;
      if (sbus.data_readReg[SDW +: SDW] !== want || sbus.data_readReg[0 +: SDW] !== 16'h00FF ||
          sbus.data_readReg[2*SDW +: SDW] !== 16'h0) begin
         errors++;
         $display("FAIL small_bypass: data=%h expected port1=%h port0=00ff port2=0000",
                  sbus.data_readReg, want);
      end
      tick();
      idle_small();
   endtask

   initial begin
      idle();
      idle_small();
      test_reset();
      test_write();
      test_scoreboard();
      test_bypass();
      test_random();
      test_dump();
      test_dump_reset();
      test_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the processor's 32x32 two-read-port register file.
- Configurable data width, depth and read-port count.
- Optional write-to-read bypass.
- Per-register busy scoreboard for pipeline hazard detection.
- Sequential debug dump engine that streams every register out, one per cycle.
- Sits between decode (reads, issue marking) and writeback (writes, busy clear) in the pipelined processor.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NUM_READ, 2, number of independent combinational read ports
NUM_TAPS, 4, registers 1..NUM_TAPS exported on taps (NUM_TAPS < DEPTH)

Ports:
clock  in  1  system clock, all state updates on rising edge
ctrl_reset  in  1  synchronous, active-high reset
ctrl_writeEnable  in  1  writeback strobe
ctrl_writeReg  in  ADDR_W  writeback address
data_writeReg  in  DATA_W  writeback data
ctrl_readReg  in  NUM_READ*ADDR_W  read addresses, port i at slice [i*ADDR_W +: ADDR_W]
data_readReg  out  NUM_READ*DATA_W  read data, port i at slice [i*DATA_W +: DATA_W]
read_busy  out  NUM_READ  port i's source has a pending (unwritten) result
ctrl_issueEnable  in  1  decode marks a destination as pending
ctrl_issueReg  in  ADDR_W  destination being issued
dump_start  in  1  request a full register dump
dump_valid  out  1  dump_addr/dump_data valid this cycle
dump_addr  out  ADDR_W  register index being dumped
dump_data  out  DATA_W  register contents being dumped
dump_done  out  1  one-cycle pulse after the final dump beat
taps  out  NUM_TAPS*DATA_W  live contents of registers 1..NUM_TAPS, register k at slice [(k-1)*DATA_W +: DATA_W]

Behaviour:
Reset
- Interface: one clock, named clock; reset ctrl_reset, synchronous and active-high.
- On ctrl_reset at a rising edge: all registers 0, all busy bits 0, dump FSM to IDLE.
- Outputs next cycle: dump_valid=0, dump_done=0, dump_addr=0, dump_data=0.
- Reset overrides any write, issue or dump activity in the same cycle.

Register 0
- Reads 0 and is never busy.
- Writes and issues to address 0 are ignored.

Write
- At a rising edge with ctrl_writeEnable=1 and ctrl_writeReg!=0, mem[ctrl_writeReg] <= data_writeReg.

Read
- Purely combinational, zero latency: data_readReg[i] = mem[addr_i].
- With bypass compiled in, see Optional Feature.

Scoreboard
- Issue: ctrl_issueEnable=1 and ctrl_issueReg!=0 sets busy[ctrl_issueReg].
- Writeback: ctrl_writeEnable=1 with ctrl_writeReg!=0 clears busy[ctrl_writeReg].
- Issue and writeback to the same register in the same cycle: busy ends at 1 (the new producer wins).
- read_busy[i] = busy[addr_i], except as modified by the bypass rule (see Optional Feature).

Dump FSM (IDLE, SCAN, DONE)
- IDLE: dump_start -> SCAN with index=0.
- SCAN: dump_valid=1, dump_addr=index, dump_data=mem[index] as held at the start of that cycle, i.e. before any same-cycle write. Index increments by 1 per cycle.
- SCAN, index=DEPTH-1: -> DONE.
- DONE: dump_done=1 for one cycle -> IDLE.
- dump_start is ignored in SCAN and DONE.
- Normal reads, writes and issues continue unaffected during a dump.
- A full dump takes DEPTH beats plus 1 done cycle.
- Reset mid-SCAN aborts the dump; no dump_done is produced.

Taps
- Combinational view of mem[1..NUM_TAPS].

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN
Defined
- If ctrl_writeEnable=1, ctrl_writeReg!=0 and ctrl_writeReg==addr_i: data_readReg[i]=data_writeReg and read_busy[i]=0.
- The rule is evaluated independently for every read port.
Undefined
- Reads return the stored value only.
- read_busy[i] is also 1 when a same-cycle write targets addr_i, so consumers stall one cycle.
Dump data is never bypassed in either build.

Decomposition:
Package regfile_pkg:
- dump FSM state enum (IDLE, SCAN, DONE);
- default DATA_W/ADDR_W constants;
- the zero-register index constant.

Sub-module regfile_read_port:
- address decode/mux, bypass compare and read_busy logic for one port;
- instantiated NUM_READ times via generate.

Test Plan:
- Reset, then write r5=0xDEADBEEF -> next cycle port0 addr5 reads 0xDEADBEEF; write to r0 with 0x1234 -> r0 still reads 0.
- Issue r7, then read r7 -> read_busy=1. Writeback r7=0x55 with issue r7 in the same cycle -> busy stays 1. Later writeback-only -> read_busy=0.
- With REGFILE_WRITE_BYPASS_EN, write r3=0xA5A5A5A5 while ports 0 and 1 both read r3 -> both ports return 0xA5A5A5A5 that cycle, read_busy=0. Without the macro -> old value is returned and read_busy=1.
- ADDR_W=5 dump after loading r1..r31 with their own index -> 32 beats, dump_addr 0..31, dump_data equals the index, then a single dump_done pulse. A dump_start pulsed mid-scan has no effect.
- Reset at beat 10 of a dump -> dump_valid=0 next cycle, no dump_done, all registers read 0.
- NUM_READ=3, DATA_W=16, NUM_TAPS=2 build: write r1=0x00FF, r2=0x0F0F -> taps=0x0F0F00FF and all three ports read correctly.
